// File: rtl/camera_wr_synchro.sv
// camera_wr_synchro: write-side frame synchroniser, camera byte stream -> SDRAM write FIFO.
// Ports:
//   clk, rst_n          camera pixel clock, asynchronous active-low reset
//   cam_vsync/href/data camera timing and byte stream (high byte first)
//   one_flag/two_flag   one-cycle game-state requests (two_flag wins)
//   sdram_rst_n         one-cycle active-low FIFO/address reset on game-state change
//   sdram_wren/wdata    one write strobe per packed RGB565 pixel
//   frame_done/err      end-of-frame status pulses
module camera_wr_synchro #(
    parameter int SKIP_FRAMES = 10,
    parameter int H_PIXELS    = 640,
    parameter int V_LINES     = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        one_flag,
    input  logic        two_flag,
    output logic        sdram_rst_n,
    output logic        sdram_wren,
    output logic [15:0] sdram_wdata,
    output logic        frame_done,
    output logic        frame_err
);
    typedef enum logic [1:0] {SKIP, ARM, ACTIVE} state_t;
    state_t      state, state_nxt;
    logic        vs_r1, vs_r2, href_r1, href_r2;
    logic [7:0]  data_r1, hi_byte;
    logic        tog, line_err, one_state, two_state;
    logic [10:0] pix_cnt, line_cnt;
    logic [15:0] skip_cnt;
    logic        vs_fall, vs_rise, href_rise, href_fall;
    logic        change, active, pack, wr_go, frame_ok;

    always_comb begin
        vs_fall   = ~vs_r1 & vs_r2;
        vs_rise   = vs_r1 & ~vs_r2;
        href_rise = href_r1 & ~href_r2;
        href_fall = ~href_r1 & href_r2;
        // two_flag has priority when both requests arrive together
        change    = two_flag ? ~two_state : (one_flag & ~one_state);
        active    = state == ACTIVE;
        // href while vsync is high is blanking garbage, never packed
        pack      = active & href_r1 & ~vs_r1;
        wr_go     = pack & tog;
        frame_ok  = (line_cnt == 11'(V_LINES)) & ~line_err;
        state_nxt = state;
        case (state)
            SKIP:    state_nxt = (vs_rise && skip_cnt == 16'(SKIP_FRAMES - 1)) ? ARM : SKIP;
            ARM:     state_nxt = vs_fall ? ACTIVE : ARM;
            ACTIVE:  state_nxt = (change | vs_rise) ? ARM : ACTIVE;
            default: state_nxt = SKIP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= SKIP;
        else        state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r1   <= 1'b0;
            vs_r2   <= 1'b0;
            href_r1 <= 1'b0;
            href_r2 <= 1'b0;
            data_r1 <= 8'd0;
        end else begin
            vs_r1   <= cam_vsync;
            vs_r2   <= vs_r1;
            href_r1 <= cam_href;
            href_r2 <= href_r1;
            data_r1 <= cam_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            one_state   <= 1'b1;
            two_state   <= 1'b0;
            sdram_rst_n <= 1'b1;
        end else begin
            sdram_rst_n <= ~change;
            if (two_flag) begin
                two_state <= 1'b1;
                one_state <= 1'b0;
            end else if (one_flag) begin
                one_state <= 1'b1;
                two_state <= 1'b0;
            end
        end
    end

    // settling frames are counted only while in SKIP, so a reset restarts the count
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)              skip_cnt <= 16'd0;
        else if (state != SKIP)  skip_cnt <= 16'd0;
        else if (vs_rise)        skip_cnt <= skip_cnt + 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog         <= 1'b0;
            hi_byte     <= 8'd0;
            sdram_wren  <= 1'b0;
            sdram_wdata <= 16'd0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            pix_cnt     <= 11'd0;
            line_cnt    <= 11'd0;
            line_err    <= 1'b0;
        end else begin
            sdram_wren <= wr_go;
            tog        <= pack ? ~tog : 1'b0;
            if (pack && !tog) hi_byte <= data_r1;
            if (wr_go) sdram_wdata <= {hi_byte, data_r1};
            // an aborted frame reports nothing; a vs_fall seen in ACTIVE means sync was lost
            frame_done <= active & ~change & vs_rise & frame_ok;
            frame_err  <= active & ~change & ((vs_rise & ~frame_ok) | vs_fall);
            if (vs_fall) begin
                pix_cnt  <= 11'd0;
                line_cnt <= 11'd0;
                line_err <= 1'b0;
            end else if (active) begin
                if (href_rise)                      pix_cnt <= 11'd0;
                else if (wr_go && pix_cnt != 11'h7FF) pix_cnt <= pix_cnt + 11'd1;
                if (href_fall) begin
                    if (line_cnt != 11'h7FF) line_cnt <= line_cnt + 11'd1;
                    // a set toggle here means an odd trailing byte that is silently dropped
                    if (pix_cnt != 11'(H_PIXELS) || tog) line_err <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_camera_wr_synchro.sv
// tb_camera_wr_synchro: scoreboard bench for camera_wr_synchro with directed frames.
module tb_camera_wr_synchro;
    localparam int SK = 2, HP = 4, VL = 2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cam_vsync = 1'b0, cam_href = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic        one_flag = 1'b0, two_flag = 1'b0;
    logic        sdram_rst_n, sdram_wren, frame_done, frame_err;
    logic [15:0] sdram_wdata;

    camera_wr_synchro #(.SKIP_FRAMES(SK), .H_PIXELS(HP), .V_LINES(VL)) dut (
        .clk(clk), .rst_n(rst_n), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .one_flag(one_flag), .two_flag(two_flag),
        .sdram_rst_n(sdram_rst_n), .sdram_wren(sdram_wren), .sdram_wdata(sdram_wdata),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {logic [15:0] d; int c;} wr_t;
    wr_t wr_q[$];
    int  ev_q[$];
    int  rst_q[$];
    int  checks = 0, errors = 0;
    bit  exp_wr = 0, one_m = 1, two_m = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (sdram_wren) begin
            if (wr_q.size() == 0) chk("wren_unexpected", 32'(sdram_wren), 0);
            else begin
                wr_t e;
                e = wr_q.pop_front();
                chk("wdata", 32'(sdram_wdata), 32'(e.d));
                chk("wren_cycle", cyc, e.c);
            end
        end
        if (frame_done || frame_err) begin
            if (ev_q.size() == 0) chk("frame_evt_unexpected", {frame_err, frame_done}, 0);
            else chk("frame_evt", {frame_err, frame_done}, ev_q.pop_front());
        end
        if (!sdram_rst_n) begin
            if (rst_q.size() == 0) chk("sdram_rst_unexpected", 32'(sdram_rst_n), 1);
            else chk("sdram_rst_cycle", cyc, rst_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sdram_rst_n"}, 32'(sdram_rst_n), 1);
        chk({tag, "_wren"}, 32'(sdram_wren), 0);
        chk({tag, "_wdata"}, 32'(sdram_wdata), 0);
        chk({tag, "_done"}, 32'(frame_done), 0);
        chk({tag, "_err"}, 32'(frame_err), 0);
    endtask

    task automatic flags(input bit o, input bit t);
        bit ch;
        ch = t ? !two_m : (o && !one_m);
        one_flag = o;
        two_flag = t;
        if (ch) begin
            rst_q.push_back(cyc + 1);
            exp_wr = 0;
        end
        if (t) begin
            two_m = 1;
            one_m = 0;
        end else if (o) begin
            one_m = 1;
            two_m = 0;
        end
        tick();
        one_flag = 0;
        two_flag = 0;
    endtask

    task automatic send_line(input int n, input logic [7:0] base, input logic [7:0] step);
        logic [7:0] b, prev;
        wr_t e;
        b = base;
        prev = 8'd0;
        for (int i = 0; i < n; i++) begin
            cam_href = 1;
            cam_data = b;
            if (i % 2 == 1 && exp_wr) begin
                e.d = {prev, b};
                e.c = cyc + 2;
                wr_q.push_back(e);
            end
            prev = b;
            b = b + step;
            tick();
        end
        cam_href = 0;
        cam_data = 8'd0;
        ticks(3);
    endtask

    task automatic frame(input int n0, input int n1, input logic [7:0] base, input logic [7:0] step,
                         input bit wr, input int endev, input bit mid);
        cam_vsync = 0;
        ticks(4);
        exp_wr = wr;
        send_line(n0, base, step);
        if (mid) flags(0, 1);
        send_line(n1, base + 8'h40, step);
        if (endev != 0) ev_q.push_back(endev);
        exp_wr = 0;
        cam_vsync = 1;
        ticks(4);
    endtask

    initial begin
        #12;
        check_reset_vals("reset");
        rst_n = 1;
        tick();
        frame(8, 8, 8'h10, 8'h01, 0, 0, 0);
        frame(8, 8, 8'h10, 8'h01, 0, 0, 0);
        frame(8, 8, 8'hF8, 8'h27, 1, 1, 0);
        frame(7, 8, 8'h20, 8'h01, 1, 2, 0);
        frame(8, 8, 8'h30, 8'h01, 1, 0, 1);
        frame(8, 8, 8'h50, 8'h03, 1, 1, 1);
        flags(1, 0);
        ticks(2);
        flags(1, 1);
        ticks(2);
        frame(8, 8, 8'h60, 8'h05, 1, 1, 0);
        cam_vsync = 0;
        ticks(4);
        exp_wr = 1;
        for (int i = 0; i < 5; i++) begin
            wr_t e;
            cam_href = 1;
            cam_data = 8'hA0 + 8'(i);
            if (i == 1) begin
                e.d = 16'hA0A1;
                e.c = cyc + 2;
                wr_q.push_back(e);
            end
            tick();
        end
        chk("wren_before_reset", 32'(sdram_wren), 1);
        #1 rst_n = 0;
        #1 check_reset_vals("async_reset");
        cam_href = 0;
        cam_data = 8'd0;
        exp_wr = 0;
        one_m = 1;
        two_m = 0;
        #1 rst_n = 1;
        frame(8, 8, 8'h10, 8'h01, 0, 0, 0);
        frame(8, 8, 8'h10, 8'h01, 0, 0, 0);
        frame(8, 8, 8'h70, 8'h02, 1, 1, 0);
        ticks(5);
        chk("wr_q_left", wr_q.size(), 0);
        chk("ev_q_left", ev_q.size(), 0);
        chk("rst_q_left", rst_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/camera_wr_synchro.md
Name: camera_wr_synchro

Overview:
Write-side frame synchroniser between the camera byte interface and the SDRAM write FIFO. It waits for the camera to settle, then aligns writes to a camera frame boundary. It packs byte pairs into RGB565 words and pulses a write enable per pixel. It also issues an SDRAM/FIFO reset pulse whenever the game state changes, mirroring the read-side synchroniser so both ends restart on the same frame.

Parameters:
SKIP_FRAMES, 10, camera settling frames discarded after reset before the first write
H_PIXELS, 640, expected pixels (16-bit words) per href line
V_LINES, 480, expected href lines per frame

Ports:
clk  input  1  camera pixel clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
cam_vsync  input  1  camera vsync, high during vertical blanking
cam_href  input  1  camera line valid, high while bytes are valid
cam_data  input  8  camera byte, high byte first
one_flag  input  1  one-cycle request: enter game state one
two_flag  input  1  one-cycle request: enter game state two
sdram_rst_n  output  1  active-low, one-cycle reset to SDRAM write FIFO/address
sdram_wren  output  1  one-cycle write strobe per packed pixel
sdram_wdata  output  16  packed RGB565 pixel {first byte, second byte}
frame_done  output  1  one-cycle pulse, complete frame written
frame_err  output  1  one-cycle pulse, line or pixel count mismatch in the frame

Behaviour:
- Reset values: sdram_rst_n=1, sdram_wren=0, sdram_wdata=0, frame_done=0, frame_err=0. State=SKIP, one_state=1, two_state=0, all counters 0.
- Input stage: cam_vsync, cam_href and cam_data are registered once (r1), with a second vsync register for edge detection.
- vs_fall = r1 low and previous high (frame data begins). vs_rise = r1 high and previous low (frame ends).
- Game state:
  - two_flag has priority. two_flag sets two_state=1 and one_state=0. one_flag alone sets one_state=1 and two_state=0.
  - change = (one_flag & one_state==0) | (two_flag & two_state==0), where two_flag wins if both flags are high.
  - sdram_rst_n is registered: low for exactly the one cycle after change, otherwise high.
- FSM:
  - SKIP: count vs_rise events. After SKIP_FRAMES of them, go to ARM. A change in SKIP is ignored (the skip count continues).
  - ARM: on vs_fall, go to ACTIVE and clear the line and pixel counters.
  - ACTIVE: pack and write. On vs_rise, pulse frame_done if line_cnt==V_LINES and no line error occurred in the frame, else pulse frame_err; then go to ARM. On change, abort to ARM the next cycle. No frame_done or frame_err is issued for an aborted frame.
- Packing (ACTIVE only):
  - A byte toggle runs while r1 href is high. Toggle 0 latches the high byte. Toggle 1 forms the word and asserts sdram_wren.
  - sdram_wren goes high on the edge after r1 holds the second byte, i.e. 2 clk after that byte is on cam_data, for exactly 1 cycle per pixel.
  - sdram_wdata is valid while wren is high and holds its value otherwise.
  - The toggle clears whenever href is low.
- Counters:
  - pix_cnt (11 bit) increments per wren and clears at href rise.
  - On href fall, line_cnt (11 bit) increments. A line error is flagged if pix_cnt != H_PIXELS or a dangling odd byte exists. The dangling byte is dropped, with no wren.
  - Both counters saturate at 2047.
- Edge cases:
  - change on the same cycle as a wren: that wren is still issued, then writing stops.
  - vs_fall in ACTIVE without a preceding vs_rise (lost sync): treat it as a new frame start. Clear the counters and pulse frame_err.
  - href high while vsync is high: ignored, no writes.
  - Asynchronous reset mid-frame forces the reset values immediately, and the block re-enters SKIP.

Test Plan:
1. Reset, SKIP_FRAMES=2, H_PIXELS=4, V_LINES=2; drive 3 frames → no wren in frames 1–2. Frame 3 gives 8 wren pulses, then frame_done=1 for one cycle at vsync rise.
2. Bytes 0xF8,0x1F on one line → sdram_wdata=0xF81F, with wren high 2 clk after 0x1F is presented.
3. Line with 7 bytes (odd) → 3 wren, the 7th byte is dropped, and frame_err pulses at the end of the frame instead of frame_done.
4. In ACTIVE, assert two_flag with two_state=0 → sdram_rst_n low for exactly 1 cycle, wren stops. Writing resumes only after the next vsync fall. Repeating two_flag produces no further sdram_rst_n pulse.
5. Assert one_flag and two_flag in the same cycle from one_state → two_state=1, one sdram_rst_n pulse.
6. Deassert rst_n mid-line with wren active → all outputs reach their reset values asynchronously, and the SKIP count restarts.
